// File: rtl/or1200_sha3_pkg.sv
// Shared constants, opcodes and state encoding for the OR1200 l.cust5 SHA3-512 sequencer.
package or1200_sha3_pkg;

    localparam int unsigned RATE_WORDS  = 18;
    localparam int unsigned RATE_BITS   = RATE_WORDS * 32;
    localparam int unsigned DIGEST_BITS = 512;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned DSEL_W      = 4;

    localparam logic [4:0] OP_HEAD   = 5'b00100;
    localparam logic [4:0] OP_ABSORB = 5'b00010;
    localparam logic [4:0] OP_TAIL   = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_PERM   = 2'd2,
        ST_DIGEST = 2'd3
    } state_e;

    // operand_a[31:24] is the first message byte, which lands in the lowest block byte lane.
    function automatic logic [31:0] word_lanes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/or1200_sha3_pad.sv
// Builds the final-word contribution of a SHA3 rate block: partial bytes, 0x06 domain byte and 0x80 end bit.
module or1200_sha3_pad
    import or1200_sha3_pkg::*;
(
    input  logic [CNT_W-1:0]     count_i,
    input  logic [1:0]           nbytes_i,
    input  logic [31:0]          word_i,
    output logic [RATE_BITS-1:0] block_o
);

    logic [31:0] keep_mask;
    logic [31:0] tail_word;

    always_comb begin
        case (nbytes_i)
            2'd0:    keep_mask = 32'h0000_0000;
            2'd1:    keep_mask = 32'h0000_00ff;
            2'd2:    keep_mask = 32'h0000_ffff;
            default: keep_mask = 32'h00ff_ffff;
        endcase
    end

    assign tail_word = (word_lanes(word_i) & keep_mask) | (32'(PAD_DOMAIN) << {nbytes_i, 3'b000});

    // Bytes above the pad word stay zero; the end bit may merge with the domain byte into 0x86.
    always_comb begin
        block_o = RATE_BITS'(tail_word) << {count_i, 5'b00000};
        block_o[RATE_BITS-1 -: 8] = block_o[RATE_BITS-1 -: 8] | PAD_END;
    end

endmodule

// File: rtl/or1200_sha3_cust5_ctrl.sv
// l.cust5 sequencer feeding a Keccak-f[1600] core for SHA3-512.
// Optional permutation watchdog: define OR1200_SHA3_TIMEOUT_EN.
module or1200_sha3_cust5_ctrl
    import or1200_sha3_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cust5_valid,
    input  logic [4:0]             cust5_op,
    input  logic [5:0]             cust5_limm,
    input  logic [31:0]            operand_a,
    output logic [31:0]            result,
    output logic                   stall,
    output logic                   perm_start,
    output logic                   perm_init,
    output logic [RATE_BITS-1:0]   perm_block,
    input  logic                   perm_done,
    input  logic [DIGEST_BITS-1:0] digest_in,
    output logic                   err
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [RATE_BITS-1:0]   buf_q, buf_d;
    logic [DIGEST_BITS-1:0] digest_q, digest_d;
    logic                   init_pend_q, init_pend_d;
    logic                   last_q, last_d;
    logic                   dvalid_q, dvalid_d;
    logic                   err_q, err_d;
    logic                   start_q, start_d;
    logic                   pinit_q, pinit_d;
    logic                   stall_q, stall_d;

    logic                   is_head, is_absorb, is_tail, is_store, is_cmd;
    logic [RATE_BITS-1:0]   pad_block;
    logic                   unused_limm;

`ifdef OR1200_SHA3_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned WD_W    = 8;
    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_d = (state_q == ST_PERM) ? wd_q + WD_W'(1) : '0;
`endif

    assign is_head   = cust5_valid && (cust5_op == OP_HEAD);
    assign is_absorb = cust5_valid && (cust5_op == OP_ABSORB);
    assign is_tail   = cust5_valid && (cust5_op == OP_TAIL);
    assign is_store  = cust5_valid && (cust5_op == OP_STORE);
    assign is_cmd    = is_head || is_absorb || is_tail || is_store;

    assign unused_limm = ^cust5_limm[5:4];

    or1200_sha3_pad u_pad (
        .count_i  (count_q),
        .nbytes_i (cust5_limm[1:0]),
        .word_i   (operand_a),
        .block_o  (pad_block)
    );

    // Next-state and command handling.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        buf_d       = buf_q;
        digest_d    = digest_q;
        init_pend_d = init_pend_q;
        last_d      = last_q;
        dvalid_d    = dvalid_q;
        err_d       = err_q;
        start_d     = 1'b0;
        pinit_d     = 1'b0;

        case (state_q)
            ST_PERM: begin
                if (is_cmd) err_d = 1'b1;
                if (perm_done) begin
                    last_d = 1'b0;
                    if (last_q) begin
                        digest_d = digest_in;
                        dvalid_d = 1'b1;
                        state_d  = ST_DIGEST;
                    end else begin
                        buf_d   = '0;
                        count_d = '0;
                        state_d = ST_ABSORB;
                    end
                end
`ifdef OR1200_SHA3_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    err_d    = 1'b1;
                    dvalid_d = 1'b0;
                    last_d   = 1'b0;
                end
`endif
            end
            default: begin
                if (is_head) begin
                    buf_d       = RATE_BITS'(word_lanes(operand_a));
                    count_d     = CNT_W'(1);
                    init_pend_d = 1'b1;
                    dvalid_d    = 1'b0;
                    last_d      = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_ABSORB;
                end else if (is_absorb || is_tail) begin
                    if (state_q != ST_ABSORB) begin
                        err_d = 1'b1;
                    end else if (is_tail) begin
                        // Words above count are already zero, so OR-ing the pad block is enough.
                        buf_d       = buf_q | pad_block;
                        last_d      = 1'b1;
                        state_d     = ST_PERM;
                        start_d     = 1'b1;
                        pinit_d     = init_pend_q;
                        init_pend_d = 1'b0;
                    end else begin
                        buf_d   = buf_q | (RATE_BITS'(word_lanes(operand_a)) << {count_q, 5'b00000});
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(RATE_WORDS - 1)) begin
                            state_d     = ST_PERM;
                            start_d     = 1'b1;
                            pinit_d     = init_pend_q;
                            init_pend_d = 1'b0;
                        end
                    end
                end
                if (is_store && !dvalid_q) err_d = 1'b1;
                if (perm_done) err_d = 1'b1;
            end
        endcase

        stall_d = (state_d == ST_PERM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            buf_q       <= '0;
            digest_q    <= '0;
            init_pend_q <= 1'b0;
            last_q      <= 1'b0;
            dvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            pinit_q     <= 1'b0;
            stall_q     <= 1'b0;
`ifdef OR1200_SHA3_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            buf_q       <= buf_d;
            digest_q    <= digest_d;
            init_pend_q <= init_pend_d;
            last_q      <= last_d;
            dvalid_q    <= dvalid_d;
            err_q       <= err_d;
            start_q     <= start_d;
            pinit_q     <= pinit_d;
            stall_q     <= stall_d;
`ifdef OR1200_SHA3_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign result     = dvalid_q ? 32'(digest_q >> {cust5_limm[DSEL_W-1:0], 5'b00000}) : 32'h0;
    assign stall      = stall_q;
    assign perm_start = start_q;
    assign perm_init  = pinit_q;
    assign perm_block = buf_q;
    assign err        = err_q;

endmodule

// File: tb/tb_or1200_sha3_cust5_ctrl.sv
// Bench for the l.cust5 SHA3 sequencer: stub Keccak core plus a byte-queue message model.
module tb_or1200_sha3_cust5_ctrl;

    localparam logic [4:0] C_HEAD   = 5'b00100;
    localparam logic [4:0] C_ABSORB = 5'b00010;
    localparam logic [4:0] C_TAIL   = 5'b00001;
    localparam logic [4:0] C_STORE  = 5'b01000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cust5_valid = 1'b0;
    logic [4:0]   cust5_op = '0;
    logic [5:0]   cust5_limm = '0;
    logic [31:0]  operand_a = '0;
    logic [31:0]  result;
    logic         stall;
    logic         perm_start;
    logic         perm_init;
    logic [575:0] perm_block;
    logic         perm_done = 1'b0;
    logic [511:0] digest_in;
    logic         err;

    int checks = 0;
    int failures = 0;

    // Stub core state
    int           core_cnt = 0;
    int           core_delay = 24;
    bit           core_silent = 1'b0;
    int           n_starts = 0;
    int           stray_req = 0;
    int           stray_ack = 0;
    logic [511:0] core_digest = '0;

    // Message model
    logic [7:0]   mdl_bytes[$];
    bit           mdl_init = 1'b0;
    bit           mdl_dvalid = 1'b0;
    bit           mdl_err = 1'b0;
    logic [511:0] mdl_digest = '0;
    logic [575:0] seen_block;
    logic         seen_init;

    or1200_sha3_cust5_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cust5_valid (cust5_valid),
        .cust5_op    (cust5_op),
        .cust5_limm  (cust5_limm),
        .operand_a   (operand_a),
        .result      (result),
        .stall       (stall),
        .perm_start  (perm_start),
        .perm_init   (perm_init),
        .perm_block  (perm_block),
        .perm_done   (perm_done),
        .digest_in   (digest_in),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign digest_in = core_digest;

    always @(negedge clk) begin
        perm_done = 1'b0;
        if (rst) begin
            core_cnt = 0;
        end else begin
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) perm_done = 1'b1;
            end
            if (perm_start === 1'b1) begin
                n_starts++;
                if (!core_silent) core_cnt = core_delay - 1;
            end
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                perm_done = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic logic [575:0] exp_block(input bit fin);
        logic [575:0] b;
        b = '0;
        foreach (mdl_bytes[i]) b = b | (576'(mdl_bytes[i]) << (8 * i));
        if (fin) begin
            b = b | (576'(8'h06) << (8 * mdl_bytes.size()));
            b = b | (576'(8'h80) << 568);
        end
        return b;
    endfunction

    function automatic void push_word(input logic [31:0] w, input int n);
        for (int j = 0; j < n; j++) mdl_bytes.push_back(8'(w >> (24 - 8 * j)));
    endfunction

    task automatic cmd(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a);
        @(negedge clk);
        cust5_valid = 1'b1;
        cust5_op    = op;
        cust5_limm  = limm;
        operand_a   = a;
        @(negedge clk);
        cust5_valid = 1'b0;
        cust5_op    = '0;
        cust5_limm  = '0;
        operand_a   = '0;
    endtask

    // Called in the cycle after a block-launching command; follows the permutation to its end.
    task automatic run_perm(input bit fin, input int exp_cycles);
        logic [575:0] eb;
        int n;
        bit moved;
        bit long_start;
        eb = exp_block(fin);
        checks++;
        if (perm_start !== 1'b1) begin
            failures++;
            $display("FAIL perm_start: got %b want 1", perm_start);
        end
        checks++;
        if (perm_init !== mdl_init) begin
            failures++;
            $display("FAIL perm_init: got %b want %b", perm_init, mdl_init);
        end
        checks++;
        if (perm_block !== eb) begin
            failures++;
            $display("FAIL perm_block: got %h want %h", perm_block, eb);
        end
        seen_block = perm_block;
        seen_init  = perm_init;
        n = 0;
        moved = 1'b0;
        long_start = 1'b0;
        while (stall === 1'b1 && n < 600) begin
            if (perm_block !== seen_block) moved = 1'b1;
            if (n > 0 && perm_start !== 1'b0) long_start = 1'b1;
            n++;
            @(negedge clk);
        end
        checks++;
        if (moved || long_start) begin
            failures++;
            $display("FAIL perm_hold: block_moved=%b start_longer_than_1=%b want 0 0", moved, long_start);
        end
        checks++;
        if (n != exp_cycles) begin
            failures++;
            $display("FAIL stall_cycles: got %0d want %0d", n, exp_cycles);
        end
        mdl_init = 1'b0;
        if (fin) begin
            mdl_dvalid = 1'b1;
            mdl_digest = core_digest;
        end else begin
            mdl_bytes.delete();
        end
    endtask

    task automatic do_head(input logic [31:0] w);
        cmd(C_HEAD, 6'd0, w);
        mdl_bytes.delete();
        push_word(w, 4);
        mdl_init   = 1'b1;
        mdl_dvalid = 1'b0;
        mdl_err    = 1'b0;
    endtask

    task automatic do_absorb(input logic [31:0] w);
        cmd(C_ABSORB, 6'd0, w);
        push_word(w, 4);
        if (mdl_bytes.size() == 72) run_perm(1'b0, core_delay);
    endtask

    task automatic do_tail(input logic [1:0] n, input logic [31:0] w);
        cmd(C_TAIL, {4'd0, n}, w);
        push_word(w, int'(n));
        run_perm(1'b1, core_delay);
    endtask

    task automatic do_store(input logic [3:0] sel);
        logic [31:0] exp;
        @(negedge clk);
        cust5_valid = 1'b1;
        cust5_op    = C_STORE;
        cust5_limm  = {2'b00, sel};
        operand_a   = $urandom;
        #1;
        exp = mdl_dvalid ? 32'(mdl_digest >> (32 * int'(sel))) : 32'h0;
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL store_result sel=%0d: got %h want %h", sel, result, exp);
        end
        if (!mdl_dvalid) mdl_err = 1'b1;
        @(negedge clk);
        cust5_valid = 1'b0;
        cust5_op    = '0;
        cust5_limm  = '0;
        checks++;
        if (err !== mdl_err) begin
            failures++;
            $display("FAIL store_err sel=%0d: got %b want %b", sel, err, mdl_err);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mdl_bytes.delete();
        mdl_init = 1'b0; mdl_dvalid = 1'b0; mdl_err = 1'b0;
        checks++;
        if (result !== 32'h0 || stall !== 1'b0 || perm_start !== 1'b0 || perm_init !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: result=%h stall=%b start=%b init=%b err=%b want 0", result, stall, perm_start, perm_init, err);
        end
        checks++;
        if (perm_block !== 576'h0) begin
            failures++;
            $display("FAIL reset_block: got %h want 0", perm_block);
        end
        do_store(4'd15);
        do_head($urandom);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL head_clears_err: got %b want 0", err);
        end
    endtask

    task automatic test_fox;
        logic [31:0] words [11];
        int s0;
        words = '{32'h54686520, 32'h71756963, 32'h6b206272, 32'h6f776e20, 32'h666f7820, 32'h6a756d70,
                  32'h73206f76, 32'h65722074, 32'h6865206c, 32'h617a7920, 32'h646f672e};
        core_digest = {8{64'h0123456789abcdef}};
        core_delay  = 24;
        s0 = n_starts;
        do_head(words[0]);
        for (int i = 1; i < 11; i++) do_absorb(words[i]);
        do_tail(2'd0, $urandom);
        checks++;
        if (n_starts - s0 != 1 || seen_init !== 1'b1) begin
            failures++;
            $display("FAIL fox_launch: starts=%0d init=%b want 1 1", n_starts - s0, seen_init);
        end
        checks++;
        if (seen_block[359:352] !== 8'h06 || seen_block[575:568] !== 8'h80 || seen_block[351:344] !== 8'h2e) begin
            failures++;
            $display("FAIL fox_pad: byte44=%h byte71=%h byte43=%h want 06 80 2e",
                     seen_block[359:352], seen_block[575:568], seen_block[351:344]);
        end
        do_store(4'd15);
        do_store(4'd0);
    endtask

    task automatic test_full_block;
        int s0;
        core_digest = {16{$urandom}};
        core_delay  = 24;
        s0 = n_starts;
        do_head($urandom);
        repeat (17) do_absorb($urandom);
        do_tail(2'($urandom_range(0, 3)), $urandom);
        checks++;
        if (n_starts - s0 != 2 || seen_init !== 1'b0) begin
            failures++;
            $display("FAIL second_launch: starts=%0d init=%b want 2 0", n_starts - s0, seen_init);
        end
        do_store(4'($urandom_range(0, 15)));
    endtask

    task automatic test_pad_86;
        logic [31:0] w;
        core_delay = 9;
        w = {24'h616263, 8'($urandom)};
        do_head($urandom);
        repeat (16) do_absorb($urandom);
        do_tail(2'd3, w);
        checks++;
        if (seen_block[575:544] !== 32'h86636261) begin
            failures++;
            $display("FAIL pad_86: bytes71..68=%h want 86636261", seen_block[575:544]);
        end
    endtask

    task automatic test_perm_drop;
        logic [31:0] w;
        int n;
        core_delay = 30;
        do_head($urandom);
        repeat (16) do_absorb($urandom);
        w = $urandom;
        cmd(C_ABSORB, 6'd0, w);
        cmd(C_ABSORB, 6'd0, $urandom);
        checks++;
        if (err !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL absorb_in_perm: err=%b stall=%b want 1 1", err, stall);
        end
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL perm_return: stall=%b want 0", stall);
        end
        mdl_bytes.delete();
        mdl_init = 1'b0;
        mdl_err  = 1'b1;
        core_delay = 5;
        do_tail(2'd0, $urandom);
        stray_req++;
        repeat (3) @(negedge clk);
        do_head($urandom);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL head_clears_err2: got %b want 0", err);
        end
        stray_req++;
        repeat (3) @(negedge clk);
        mdl_err = 1'b1;
        checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL stray_done: err=%b stall=%b want 1 0", err, stall);
        end
    endtask

    task automatic test_rst_in_perm;
        core_delay = 40;
        do_head($urandom);
        repeat (16) do_absorb($urandom);
        cmd(C_ABSORB, 6'd0, $urandom);
        repeat (5) @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup_stall: got %b want 1", stall);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_bytes.delete();
        mdl_init = 1'b0; mdl_dvalid = 1'b0; mdl_err = 1'b0;
        checks++;
        if (stall !== 1'b0 || err !== 1'b0 || perm_start !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_perm: stall=%b err=%b start=%b want 0 0 0", stall, err, perm_start);
        end
        cmd(C_ABSORB, 6'd0, $urandom);
        mdl_err = 1'b1;
        checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL absorb_in_idle: err=%b stall=%b want 1 0", err, stall);
        end
        do_store(4'($urandom_range(0, 15)));
    endtask

    task automatic test_random;
        int nw;
        for (int m = 0; m < 6; m++) begin
            for (int k = 0; k < 16; k++) core_digest[32 * k +: 32] = $urandom;
            core_delay = $urandom_range(2, 30);
            nw = $urandom_range(0, 40);
            do_head($urandom);
            repeat (nw) do_absorb($urandom);
            do_tail(2'($urandom_range(0, 3)), $urandom);
            do_store(4'($urandom_range(0, 15)));
            do_store(4'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_bad_state;
        cmd(C_ABSORB, 6'd0, $urandom);
        mdl_err = 1'b1;
        checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL absorb_in_digest: err=%b stall=%b want 1 0", err, stall);
        end
        cmd(C_TAIL, 6'd2, $urandom);
        checks++;
        if (stall !== 1'b0 || perm_start !== 1'b0) begin
            failures++;
            $display("FAIL tail_in_digest: stall=%b start=%b want 0 0", stall, perm_start);
        end
        do_store(4'($urandom_range(0, 15)));
    endtask

`ifdef OR1200_SHA3_TIMEOUT_EN
    task automatic test_timeout;
        core_silent = 1'b1;
        core_delay  = 255;
        do_head($urandom);
        repeat (17) do_absorb($urandom);
        mdl_err = 1'b1;
        checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout: err=%b stall=%b want 1 0", err, stall);
        end
        core_silent = 1'b0;
        stray_req++;
        repeat (3) @(negedge clk);
        do_store(4'd7);
        core_delay = 24;
    endtask
`endif

    initial begin
        test_reset();
        test_fox();
        test_full_block();
        test_pad_86();
        test_perm_drop();
        test_rst_in_perm();
        test_random();
        test_bad_state();
`ifdef OR1200_SHA3_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
